key_tracker: RTL



---
 rtl/key_tracker.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/key_tracker.sv
// key_tracker: turns the raw PS/2 byte stream into the single most recently
// pressed, still-held key. It decodes make/break/E0 prefixes, keeps a small
// last-pressed-priority stack of held keys, and owns the octave register.
// Optional feature macro: KEY_TRACKER_OCTAVE_KEYS_EN. When it is defined,
// F1 (8'h05) and F2 (8'h06) step the octave down/up and are never stacked.
//
// Handshake: ps2_byte is qualified by the one-cycle strobe ps2_byte_valid.
// There is no backpressure. A strobe may arrive on every cycle, and every
// strobed byte is consumed in the cycle in which it is presented.
module key_tracker #(
  parameter int         DEPTH       = 4,
  parameter logic [2:0] OCTAVE_INIT = 3'd4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] ps2_byte,
  input  logic       ps2_byte_valid,
  output logic [7:0] key_code,
  output logic       key_valid,
  output logic       key_event,
  output logic [2:0] GLOBAL_octave,
  output logic [1:0] fsm_state
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_BREAK     = 2'd1,
    S_EXT       = 2'd2,
    S_EXT_BREAK = 2'd3
  } state_t;

  state_t     state, state_nxt;
  logic       do_make, do_release;
  logic       stack_make, stack_release;
  logic [7:0] code_q [DEPTH];
  logic [7:0] code_d [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  logic       hit;
  int         hit_idx;
  logic [7:0] top_d;

  assign fsm_state = state;

  // Prefix decoder: advances only on strobed bytes and flags make/release.
  always_comb begin
    state_nxt  = state;
    do_make    = 1'b0;
    do_release = 1'b0;
    if (ps2_byte_valid) begin
      case (state)
        S_IDLE: begin
          case (ps2_byte)
            8'hF0: state_nxt = S_BREAK;
            8'hE0: state_nxt = S_EXT;
            8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'hFF, 8'h00: state_nxt = S_IDLE;
            default: do_make = 1'b1;
          endcase
        end
        S_BREAK: begin
          do_release = 1'b1;
          state_nxt  = S_IDLE;
        end
        S_EXT: state_nxt = (ps2_byte == 8'hF0) ? S_EXT_BREAK : S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Prefix state register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

`ifdef KEY_TRACKER_OCTAVE_KEYS_EN
  logic       is_oct_key;
  logic [2:0] octave_q;

  assign is_oct_key    = (ps2_byte == 8'h05) || (ps2_byte == 8'h06);
  assign stack_make    = do_make && !is_oct_key;
  assign stack_release = do_release && !is_oct_key;
  assign GLOBAL_octave = octave_q;

  // Octave register: F1 steps down, F2 steps up, both saturating.
  always_ff @(posedge clk) begin
    if (reset) begin
      octave_q <= OCTAVE_INIT;
    end else if (do_make && ps2_byte == 8'h05 && octave_q != 3'd0) begin
      octave_q <= octave_q - 3'd1;
    end else if (do_make && ps2_byte == 8'h06 && octave_q != 3'd7) begin
      octave_q <= octave_q + 3'd1;
    end
  end
`else
  assign stack_make    = do_make;
  assign stack_release = do_release;
  assign GLOBAL_octave = OCTAVE_INIT;
`endif

  // Next stack contents. The stack is always compact from entry 0 down, so a
  // missing code on make behaves like a hit at the oldest slot, which is dropped.
  always_comb begin
    code_d  = code_q;
    vld_d   = vld_q;
    hit     = 1'b0;
    hit_idx = DEPTH - 1;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (vld_q[i] && code_q[i] == ps2_byte) begin
        hit     = 1'b1;
        hit_idx = i;
      end
    end
    if (stack_make) begin
      if (!(hit && hit_idx == 0)) begin
        code_d[0] = ps2_byte;
        vld_d[0]  = 1'b1;
        for (int i = 1; i < DEPTH; i++) begin
          if (i <= hit_idx) begin
            code_d[i] = code_q[i-1];
            vld_d[i]  = vld_q[i-1];
          end
        end
      end
    end else if (stack_release && hit) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        if (i >= hit_idx) begin
          code_d[i] = code_q[i+1];
          vld_d[i]  = vld_q[i+1];
        end
      end
      code_d[DEPTH-1] = 8'h00;
      vld_d[DEPTH-1]  = 1'b0;
    end
    top_d = vld_d[0] ? code_d[0] : 8'h00;
  end

  // Stack and output registers. key_event fires only when the visible code changes.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) code_q[i] <= 8'h00;
      vld_q     <= '0;
      key_code  <= 8'h00;
      key_valid <= 1'b0;
      key_event <= 1'b0;
    end else begin
      code_q    <= code_d;
      vld_q     <= vld_d;
      key_code  <= top_d;
      key_valid <= vld_d[0];
      key_event <= (top_d != key_code);
    end
  end

endmodule
